// File: rtl/ftl_addr_responder_if.sv
// Address-translation handshake between burst controller and FTL responder.
// Four-phase: addr_valid/addr_resp; response fields held while addr_resp is high.
interface ftl_addr_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  addr_valid;
    logic                  mem_rw;
    logic [ADDR_WIDTH-1:0] mem_new_address;
    logic                  addr_resp;
    logic                  cache_hit;

    modport master (
        output mem_address,
        output addr_valid,
        output mem_rw,
        input  mem_new_address,
        input  addr_resp,
        input  cache_hit
    );

    modport slave (
        input  mem_address,
        input  addr_valid,
        input  mem_rw,
        output mem_new_address,
        output addr_resp,
        output cache_hit
    );
endinterface

// File: rtl/ftl_addr_responder.sv
// FTL address responder: page map, log-structured allocator and
// direct-mapped pseudo-cache tags behind a four-phase handshake.
module ftl_addr_responder #(
    parameter int ADDR_WIDTH       = 32,
    parameter int PAGE_OFFSET_BITS = 12,
    parameter int LPN_BITS         = 6,
    parameter int PPN_BITS         = 7,
    parameter int SET_BITS         = 2,
    parameter int LOOKUP_LATENCY   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ftl_addr_responder_if.slave  bus,
    output logic                 alloc_wrap_o,
    output logic                 busy_o
);
    localparam int MAP_N    = 1 << LPN_BITS;
    localparam int SET_N    = 1 << SET_BITS;
    localparam int TAG_BITS = LPN_BITS - SET_BITS;
    localparam int LW       = $clog2(LOOKUP_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [LW-1:0]               lat_q;
    logic [LPN_BITS-1:0]         lpn_q;
    logic [PAGE_OFFSET_BITS-1:0] off_q;
    logic                        rw_q;
    logic [PPN_BITS-1:0]         free_q;
    logic                        wrap_q;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic                        hit_q;

    logic [PPN_BITS-1:0] map_q [MAP_N];
    logic [MAP_N-1:0]    map_v_q;
    logic [TAG_BITS-1:0] tag_q [SET_N];
    logic [SET_N-1:0]    tag_v_q;

    logic                accept;
    logic                last;
    logic                commit;
    logic [SET_BITS-1:0] set;
    logic [TAG_BITS-1:0] tag_in;
    logic [PPN_BITS-1:0] ppn;
    logic                hit;

    assign accept = (state_q == IDLE) && bus.addr_valid;
    // Counter runs 0..LOOKUP_LATENCY so the response lands at N+1+latency.
    assign last   = (lat_q == LW'(LOOKUP_LATENCY));
    assign commit = (state_q == LOOKUP) && last;
    assign set    = lpn_q[SET_BITS-1:0];
    assign tag_in = lpn_q[LPN_BITS-1:SET_BITS];
    assign hit    = tag_v_q[set] && (tag_q[set] == tag_in);

    always_comb begin
        ppn = PPN_BITS'(lpn_q);
        if (rw_q) begin
            ppn = free_q;
        end else if (map_v_q[lpn_q]) begin
            ppn = map_q[lpn_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.addr_valid) state_d = LOOKUP;
            LOOKUP:  if (last) state_d = RESP;
            RESP:    if (!bus.addr_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lat_q   <= '0;
            lpn_q   <= '0;
            off_q   <= '0;
            rw_q    <= 1'b0;
            free_q  <= '0;
            wrap_q  <= 1'b0;
            addr_q  <= '0;
            hit_q   <= 1'b0;
            map_v_q <= '0;
            tag_v_q <= '0;
        end else begin
            if (accept) begin
                lpn_q <= bus.mem_address[PAGE_OFFSET_BITS +: LPN_BITS];
                off_q <= bus.mem_address[PAGE_OFFSET_BITS-1:0];
                rw_q  <= bus.mem_rw;
                lat_q <= '0;
            end else if (state_q == LOOKUP && !last) begin
                lat_q <= lat_q + LW'(1);
            end
            if (commit) begin
                addr_q       <= ADDR_WIDTH'({ppn, off_q});
                hit_q        <= hit;
                tag_v_q[set] <= 1'b1;
                if (rw_q) begin
                    map_v_q[lpn_q] <= 1'b1;
                    free_q         <= free_q + PPN_BITS'(1);
                    if (&free_q) wrap_q <= 1'b1;
                end
            end
        end
    end

    // Array contents need no reset; their valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit) begin
            tag_q[set] <= tag_in;
            if (rw_q) map_q[lpn_q] <= free_q;
        end
    end

    assign bus.mem_new_address = addr_q;
    assign bus.cache_hit       = hit_q;
    assign bus.addr_resp       = (state_q == RESP);
    assign alloc_wrap_o        = wrap_q;
    assign busy_o              = (state_q != IDLE);
endmodule

// File: tb/tb_ftl_addr_responder.sv
// Directed bench for ftl_addr_responder: reset, latency, mapping,
// pseudo-cache hits/conflicts, aliasing and allocator wrap.
module tb_ftl_addr_responder;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic alloc_wrap_o;
    logic busy_o;
    int   n_cmp = 0;
    int   n_bad = 0;

    ftl_addr_responder_if #(.ADDR_WIDTH(32)) bus ();

    ftl_addr_responder dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .bus          (bus),
        .alloc_wrap_o (alloc_wrap_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tg, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tg, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bus.addr_valid = 1'b0;
        repeat (2) tick();
        rst_i = 1'b0;
    endtask

    // Accept, wait for response, check latency/fields, hold, release.
    task automatic xact(input string tg, input logic [31:0] a,
                        input logic rw, input logic [31:0] ea,
                        input logic eh);
        int n;
        bus.mem_address = a;
        bus.mem_rw      = rw;
        bus.addr_valid  = 1'b1;
        tick();
        n = 0;
        while (!bus.addr_resp && n < 20) begin
            tick();
            n++;
        end
        chk({tg, ".lat"}, n, 3);
        chk({tg, ".addr"}, bus.mem_new_address, ea);
        chk({tg, ".hit"}, {31'd0, bus.cache_hit}, {31'd0, eh});
        tick();
        chk({tg, ".hold"}, {31'd0, bus.addr_resp}, 32'd1);
        bus.addr_valid = 1'b0;
        tick();
        chk({tg, ".fall"}, {31'd0, bus.addr_resp}, 32'd0);
    endtask

    initial begin
        int n;
        bus.mem_address = '0;
        bus.mem_rw      = 1'b0;
        bus.addr_valid  = 1'b0;
        do_reset();
        tick();
        chk("rst.resp", {31'd0, bus.addr_resp}, 32'd0);
        chk("rst.addr", bus.mem_new_address, 32'd0);
        chk("rst.hit", {31'd0, bus.cache_hit}, 32'd0);
        chk("rst.wrap", {31'd0, alloc_wrap_o}, 32'd0);
        chk("rst.busy", {31'd0, busy_o}, 32'd0);

        // Reset while in RESP aborts and clears the map.
        bus.mem_address = 32'h0000_3ABC;
        bus.mem_rw      = 1'b1;
        bus.addr_valid  = 1'b1;
        tick();
        n = 0;
        while (!bus.addr_resp && n < 20) begin
            tick();
            n++;
        end
        chk("rr.resp", {31'd0, bus.addr_resp}, 32'd1);
        rst_i = 1'b1;
        tick();
        chk("rr.resp0", {31'd0, bus.addr_resp}, 32'd0);
        chk("rr.addr0", bus.mem_new_address, 32'd0);
        chk("rr.busy0", {31'd0, busy_o}, 32'd0);
        rst_i = 1'b0;
        bus.addr_valid = 1'b0;
        tick();
        xact("rr.rd3", 32'h0000_3010, 1'b0, 32'h0000_3010, 1'b0);

        do_reset();
        xact("w3a", 32'h0000_3ABC, 1'b1, 32'h0000_0ABC, 1'b0);
        xact("r3a", 32'h0000_3010, 1'b0, 32'h0000_0010, 1'b1);
        xact("w3b", 32'h0000_3ABC, 1'b1, 32'h0000_1ABC, 1'b1);
        xact("r9a", 32'h0000_9004, 1'b0, 32'h0000_9004, 1'b0);
        xact("r9b", 32'h0000_9004, 1'b0, 32'h0000_9004, 1'b1);
        xact("r7", 32'h0000_7000, 1'b0, 32'h0000_7000, 1'b0);
        xact("r3b", 32'h0000_3010, 1'b0, 32'h0000_1010, 1'b0);
        xact("r3c", 32'h0000_3010, 1'b0, 32'h0000_1010, 1'b1);
        xact("alias", 32'h4000_3010, 1'b0, 32'h0000_1010, 1'b1);
        chk("nowrap", {31'd0, alloc_wrap_o}, 32'd0);

        // addr_valid dropped during LOOKUP: one-cycle response pulse.
        bus.mem_address = 32'h0000_9004;
        bus.mem_rw      = 1'b0;
        bus.addr_valid  = 1'b1;
        tick();
        bus.addr_valid = 1'b0;
        chk("drop.busy", {31'd0, busy_o}, 32'd1);
        n = 0;
        while (!bus.addr_resp && n < 20) begin
            tick();
            n++;
        end
        chk("drop.lat", n, 3);
        chk("drop.addr", bus.mem_new_address, 32'h0000_9004);
        tick();
        chk("drop.fall", {31'd0, bus.addr_resp}, 32'd0);
        chk("drop.idle", {31'd0, busy_o}, 32'd0);

        // Allocator wrap from a clean reset.
        do_reset();
        for (int i = 0; i < 128; i++) begin
            xact($sformatf("wr%0d", i), 32'h0000_0123, 1'b1,
                 32'h0000_0123 | (i << 12), (i != 0));
            chk($sformatf("wrap%0d", i), {31'd0, alloc_wrap_o},
                {31'd0, (i == 127)});
        end
        xact("wr128", 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
        chk("wrap128", {31'd0, alloc_wrap_o}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
